led_matrix_scanner: RTL

- Parametrised row-scanning driver for an LED dot matrix.
- Multiplexes one row at a time, holds each pattern for a fixed number of frames, then steps through a pattern set.
- Supports forward/reverse sequencing, run/hold and single-step.
- Sits between the board clock divider (`row_clk`) and the matrix row/column pins. It is the generalised successor to the fixed 8x8, four-pattern display driver.

---
 rtl/led_matrix_pkg.sv | 49 ++++
 rtl/led_pattern_rom.sv | 30 +++
 rtl/led_matrix_scanner.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared constants and pattern generator for the LED matrix scanner
//
// Contents:
//   DIR_FWD / DIR_REV    : sequencing direction encodings for the dir input
//   pat_kind_e           : the four built-in pattern kinds (selected by pattern index mod 4)
//   PAT_MAX_COLS         : widest column vector pat_column can produce
//   pat_column(p,r,rows,cols) : column bits for pattern p on row r, LSB-aligned, cols bits valid

package led_matrix_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int PAT_MAX_COLS = 64;

    typedef enum logic [1:0] {
        PAT_CHECKER = 2'd0,
        PAT_DIAG    = 2'd1,
        PAT_ONES    = 2'd2,
        PAT_BORDER  = 2'd3
    } pat_kind_e;

    // Bits at or above cols are always zero so callers may simply truncate.
    function automatic logic [PAT_MAX_COLS-1:0] pat_column(
        input int p,
        input int r,
        input int rows,
        input int cols
    );
        logic [PAT_MAX_COLS-1:0] res;
        pat_kind_e               kind;
        res  = '0;
        kind = pat_kind_e'(p[1:0]);
        for (int i = 0; i < PAT_MAX_COLS; i++) begin
            if (i < cols) begin
                case (kind)
                    // MSB is lit on even rows; odd rows are the complement.
                    PAT_CHECKER: res[i] = ((((cols - 1 - i) % 2) == 0) != ((r % 2) == 1));
                    PAT_DIAG:    res[i] = (i == (r % cols));
                    PAT_ONES:    res[i] = 1'b1;
                    PAT_BORDER:  res[i] = (r == 0) || (r == rows - 1) || (i == 0) || (i == cols - 1);
                    default:     res[i] = 1'b0;
                endcase
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_pattern_rom.sv
// rtl/led_pattern_rom.sv - combinational (pattern, row) to column-data lookup
//
// Parameters: ROWS, COLS, NUM_PAT (see led_matrix_scanner)
// Ports:
//   pat     in  clog2(NUM_PAT)  pattern index
//   row_sel in  clog2(ROWS)     row being looked up
//   column  out COLS            active-high column bits for that row

module led_pattern_rom
    import led_matrix_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int NUM_PAT = 4
) (
    input  logic [$clog2(NUM_PAT)-1:0] pat,
    input  logic [$clog2(ROWS)-1:0]    row_sel,
    output logic [COLS-1:0]            column
);

    logic [PAT_MAX_COLS-1:0] full;

    assign full   = pat_column(int'(pat), int'(row_sel), ROWS, COLS);
    assign column = full[COLS-1:0];

    // Upper bits of the generator are zero padding beyond COLS.
    logic unused_hi;
    assign unused_hi = &{1'b0, full};

endmodule

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - row-scanning LED matrix driver with pattern sequencing
//
// Optional feature: define LED_SCAN_BLANK_EN to blank row/column on the last dwell
// cycle of every row (anti-ghosting gap). Undefined: rows are driven for all DWELL cycles.
//
// Parameters: ROWS, COLS, NUM_PAT, DWELL (cycles per row), FRAMES (frames per pattern)
// Ports:
//   row_clk    in   scan clock, all state on rising edge
//   reset      in   asynchronous active-low reset
//   run        in   1 = auto-advance patterns, 0 = hold
//   step       in   single-advance request while run=0 (taken at next frame boundary)
//   dir        in   0 = forward, 1 = reverse
//   row        out  ROWS one-hot active-low row select (all ones = off), registered
//   column     out  COLS active-high column data, registered
//   rowcount   out  current scan row index
//   pat_idx    out  current pattern index
//   frame_tick out  one-cycle pulse in the cycle after rowcount wraps to 0

module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int NUM_PAT = 4,
    parameter int DWELL   = 4,
    parameter int FRAMES  = 4
) (
    input  logic                       row_clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       step,
    input  logic                       dir,
    output logic [ROWS-1:0]            row,
    output logic [COLS-1:0]            column,
    output logic [$clog2(ROWS)-1:0]    rowcount,
    output logic [$clog2(NUM_PAT)-1:0] pat_idx,
    output logic                       frame_tick
);

    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(NUM_PAT);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [PW-1:0] PAT_LAST   = PW'(NUM_PAT - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);

    logic [DW-1:0]   dwell_cnt;
    logic [FW-1:0]   frame_cnt;
    logic            step_pending;

    logic            dwell_last;
    logic            boundary;
    logic            advance;
    logic [FW-1:0]   frame_cnt_nxt;
    logic [PW-1:0]   pat_idx_nxt;
    logic            step_pending_nxt;
    logic [COLS-1:0] rom_column;

    led_pattern_rom #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .NUM_PAT (NUM_PAT)
    ) u_rom (
        .pat     (pat_idx),
        .row_sel (rowcount),
        .column  (rom_column)
    );

    assign dwell_last = (dwell_cnt == DWELL_LAST);
    // Frame boundary: the edge on which rowcount wraps from ROWS-1 back to 0.
    assign boundary   = dwell_last && (rowcount == ROW_LAST);

    // Wraps modulo NUM_PAT explicitly so non-power-of-two pattern counts work.
    function automatic logic [PW-1:0] step_pat(input logic [PW-1:0] idx, input logic d);
        if (d == DIR_REV) begin
            return (idx == '0) ? PAT_LAST : idx - PW'(1);
        end
        return (idx == PAT_LAST) ? '0 : idx + PW'(1);
    endfunction

    always_comb begin
        frame_cnt_nxt    = frame_cnt;
        pat_idx_nxt      = pat_idx;
        step_pending_nxt = step_pending;
        advance          = 1'b0;

        if (run) begin
            // Steps are ignored in run mode; any leftover request is dropped.
            step_pending_nxt = 1'b0;
            if (boundary) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt_nxt = '0;
                    advance       = 1'b1;
                end else begin
                    frame_cnt_nxt = frame_cnt + FW'(1);
                end
            end
        end else begin
            if (boundary && step_pending) begin
                frame_cnt_nxt    = '0;
                advance          = 1'b1;
                // A step landing on the consuming edge is kept for the next frame.
                step_pending_nxt = step;
            end else begin
                step_pending_nxt = step_pending | step;
            end
        end

        if (advance) begin
            pat_idx_nxt = step_pat(pat_idx, dir);
        end
    end

    always_ff @(posedge row_clk or negedge reset) begin
        if (!reset) begin
            dwell_cnt    <= '0;
            rowcount     <= '0;
            frame_cnt    <= '0;
            pat_idx      <= '0;
            step_pending <= 1'b0;
            frame_tick   <= 1'b0;
            row          <= '1;
            column       <= '0;
        end else begin
            dwell_cnt <= dwell_last ? '0 : dwell_cnt + DW'(1);
            if (dwell_last) begin
                rowcount <= (rowcount == ROW_LAST) ? '0 : rowcount + RW'(1);
            end
            frame_tick   <= boundary;
            frame_cnt    <= frame_cnt_nxt;
            pat_idx      <= pat_idx_nxt;
            step_pending <= step_pending_nxt;

`ifdef LED_SCAN_BLANK_EN
            if (dwell_last) begin
                row    <= '1;
                column <= '0;
            end else begin
                row    <= ~(ROWS'(1) << rowcount);
                column <= rom_column;
            end
`else
            row    <= ~(ROWS'(1) << rowcount);
            column <= rom_column;
`endif
        end
    end

endmodule
